// File: rtl/semaforo_ctrl.sv
// Traffic-light phase controller: 1 s prescaler, GREEN/YELLOW/RED countdown, BCD digit.
// Optional night blink mode is built only when NIGHT_BLINK_EN is defined.
module semaforo_ctrl #(
  parameter int CLK_DIV  = 50000000,
  parameter int T_GREEN  = 7,
  parameter int T_YELLOW = 2,
  parameter int T_RED    = 7,
  parameter int PED_MIN  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  input  logic       night,
  output logic       lamp_r,
  output logic       lamp_y,
  output logic       lamp_g,
  output logic [3:0] digit,
  output logic [1:0] phase,
  output logic       tick
);

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    BLINK  = 2'b11
  } state_t;

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  state_t       st;
  logic [W-1:0] pre;
  logic         shorten;
  logic         wrap;
  logic         adv;

  assign phase   = st;
  assign wrap    = (pre == LAST);
  assign adv     = en && tick;
  assign shorten = en && (st == GREEN) && ped_req
                && (digit > 4'(PED_MIN));

`ifndef NIGHT_BLINK_EN
  logic unused_night;
  assign unused_night = night;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre    <= '0;
      tick   <= 1'b0;
      st     <= RED;
      digit  <= 4'(T_RED);
      lamp_r <= 1'b1;
      lamp_y <= 1'b0;
      lamp_g <= 1'b0;
    end else begin
      // A shortened green restarts the second so a full one passes
      if (en) begin
        pre  <= (shorten || wrap) ? '0 : pre + 1'b1;
        tick <= wrap && !shorten;
      end else begin
        tick <= 1'b0;
      end
`ifdef NIGHT_BLINK_EN
      if (adv && st == BLINK) begin
        if (night) begin
          lamp_y <= ~lamp_y;
        end else begin
          st     <= RED;
          digit  <= 4'(T_RED);
          lamp_r <= 1'b1;
          lamp_y <= 1'b0;
        end
      end else if (adv && night) begin
        st     <= BLINK;
        digit  <= 4'd0;
        lamp_r <= 1'b0;
        lamp_g <= 1'b0;
        lamp_y <= 1'b1;
      end else
`endif
      if (shorten) begin
        digit <= 4'(PED_MIN);
      end else if (adv) begin
        if (digit > 4'd1) begin
          digit <= digit - 4'd1;
        end else begin
          case (st)
            RED: begin
              st     <= GREEN;
              digit  <= 4'(T_GREEN);
              lamp_r <= 1'b0;
              lamp_g <= 1'b1;
            end
            GREEN: begin
              st     <= YELLOW;
              digit  <= 4'(T_YELLOW);
              lamp_g <= 1'b0;
              lamp_y <= 1'b1;
            end
            default: begin
              st     <= RED;
              digit  <= 4'(T_RED);
              lamp_r <= 1'b1;
              lamp_y <= 1'b0;
              lamp_g <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Parameter range sanity, simulation only
  always @(posedge clk) begin
    assert (CLK_DIV >= 2
         && T_GREEN >= 1 && T_GREEN <= 9
         && T_YELLOW >= 1 && T_YELLOW <= 9
         && T_RED >= 1 && T_RED <= 9
         && PED_MIN >= 1 && PED_MIN <= T_GREEN)
      else $error("semaforo_ctrl: parameter out of range");
  end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed + random bench for semaforo_ctrl against a seconds-level model.
module tb_semaforo_ctrl;
  localparam int CLK_DIV = 4;
  localparam int T_G = 7;
  localparam int T_Y = 2;
  localparam int T_R = 7;
  localparam int PED_MIN = 2;
`ifdef NIGHT_BLINK_EN
  localparam bit NIGHT = 1'b1;
`else
  localparam bit NIGHT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic ped_req = 1'b0;
  logic night = 1'b0;
  logic lamp_r, lamp_y, lamp_g, tick;
  logic [3:0] digit;
  logic [1:0] phase;

  int total = 0;
  int bad = 0;

  semaforo_ctrl #(
    .CLK_DIV(CLK_DIV), .T_GREEN(T_G), .T_YELLOW(T_Y),
    .T_RED(T_R), .PED_MIN(PED_MIN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req),
    .night(night), .lamp_r(lamp_r), .lamp_y(lamp_y),
    .lamp_g(lamp_g), .digit(digit), .phase(phase), .tick(tick)
  );

  always #5 clk = ~clk;

  // Model: phase index (0 red,1 green,2 yellow,3 blink), seconds left,
  // clocks elapsed in the current second, pending tick, blink lamp.
  int dur[3] = '{T_R, T_G, T_Y};
  int nxt[3] = '{1, 2, 0};
  int m_ph, m_rem, m_pre;
  bit m_tick, m_ly;
  int ticks;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_rem = T_R; m_pre = 0; m_tick = 0; m_ly = 0;
  endtask

  function automatic logic [9:0] exp_vec();
    logic r, y, g;
    r = (m_ph == 0);
    g = (m_ph == 1);
    y = (m_ph == 2) || (m_ph == 3 && m_ly);
    return {2'(m_ph), 4'(m_rem), r, y, g, m_tick};
  endfunction

  task automatic model_update(input bit e, input bit p, input bit n);
    bit sh;
    sh = e && m_ph == 1 && p && m_rem > PED_MIN;
    if (!e) begin
      m_tick = 0;
      return;
    end
    if (NIGHT && m_tick && (m_ph == 3 || n)) begin
      if (m_ph == 3) begin
        if (n) m_ly = !m_ly;
        else begin m_ph = 0; m_rem = T_R; end
      end else begin
        m_ph = 3; m_rem = 0; m_ly = 1;
      end
    end else if (sh) begin
      m_rem = PED_MIN;
    end else if (m_tick) begin
      if (m_rem > 1) m_rem--;
      else begin m_ph = nxt[m_ph]; m_rem = dur[m_ph]; end
    end
    if (sh) begin m_pre = 0; m_tick = 0; end
    else if (m_pre == CLK_DIV - 1) begin m_pre = 0; m_tick = 1; end
    else begin m_pre++; m_tick = 0; end
  endtask

  task automatic step(input bit e, input bit p, input bit n);
    en = e; ped_req = p; night = n;
    model_update(e, p, n);
    @(posedge clk);
    #1;
    if (tick) ticks++;
    check("cycle", 32'({phase, digit, lamp_r, lamp_y, lamp_g, tick}),
          32'(exp_vec()));
  endtask

  initial begin
    int n;
    // Reset state
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'({phase, digit, lamp_r, lamp_y, lamp_g, tick}),
          32'({2'b00, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0}));
    rst = 1'b0;

    // One full cycle: 16 ticks, back to red 7
    ticks = 0;
    repeat (65) step(1, 0, 0);
    check("ticks_cycle", ticks, 16);
    check("cycle_wrap", 32'({phase, digit}), 32'({2'b00, 4'd7}));

    // Pedestrian shortening at green 6
    n = 0;
    while (!(m_ph == 1 && m_rem == 6) && n < 200) begin
      step(1, 0, 0); n++;
    end
    check("tmo_green6", 32'(n < 200), 1);
    step(1, 1, 0);
    check("ped_digit", 32'(digit), 2);
    ticks = 0; n = 0;
    while (phase == 2'b01 && n < 40) begin step(1, 0, 0); n++; end
    check("ped_ticks", ticks, 2);
    check("ped_to_yel", 32'({phase, digit}), 32'({2'b10, 4'd2}));

    // ped held in red, and in green only once digit<=PED_MIN
    n = 0;
    while (phase != 2'b00 && n < 40) begin step(1, 1, 0); n++; end
    ticks = 0; n = 0;
    while (phase == 2'b00 && n < 60) begin step(1, 1, 0); n++; end
    check("red_ticks", ticks, 7);
    ticks = 0; n = 0;
    while (phase == 2'b01 && n < 60) begin
      step(1, m_rem <= PED_MIN, 0); n++;
    end
    check("green_ticks", ticks, 7);
    ticks = 0; n = 0;
    while (phase == 2'b10 && n < 60) begin step(1, 1, 0); n++; end
    check("yel_ticks", ticks, 2);

    // Enable freeze mid-red at digit 4
    n = 0;
    while (!(m_ph == 0 && m_rem == 4 && !m_tick) && n < 200) begin
      step(1, 0, 0); n++;
    end
    check("tmo_red4", 32'(n < 200), 1);
    repeat (10) begin
      step(0, 0, 0);
      check("frz_digit", 32'({digit, tick}), 32'({4'd4, 1'b0}));
    end
    ticks = 0; n = 0;
    while (phase == 2'b00 && n < 60) begin step(1, 0, 0); n++; end
    check("resume_ticks", ticks, 4);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit nn;
      nn = NIGHT ? ((i / 40) % 3 == 1) : 1'($urandom);
      step(($urandom % 10) != 0, ($urandom % 5) == 0, nn);
    end

    // Asynchronous reset between edges mid-yellow
    n = 0;
    while (m_ph != 2 && n < 200) begin step(1, 0, 0); n++; end
    check("tmo_yel", 32'(n < 200), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", 32'({phase, digit, lamp_r, lamp_y, lamp_g, tick}),
          32'({2'b00, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0}));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) step(1, 0, 0);

`ifdef NIGHT_BLINK_EN
    n = 0;
    while (phase != 2'b11 && n < 10) begin step(1, 0, 1); n++; end
    check("blink_in", 32'({phase, digit, lamp_y}), 32'({2'b11, 4'd0, 1'b1}));
    repeat (4) step(1, 0, 1);
    check("blink_y0", 32'({phase, lamp_y}), 32'({2'b11, 1'b0}));
    repeat (4) step(1, 1, 1);
    check("blink_y1", 32'({phase, lamp_y}), 32'({2'b11, 1'b1}));
    n = 0;
    while (phase == 2'b11 && n < 10) begin step(1, 0, 0); n++; end
    check("blink_out", 32'({phase, digit}), 32'({2'b00, 4'd7}));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
